// File: rtl/avalon_st_pkt_gen.sv
// avalon_st_pkt_gen: turns one descriptor (length, seed byte, error flag) into a
// stream of Avalon-ST beats with sop/eop/empty, and raises in_error on the eop
// beat of a flagged packet to drive a FIFO's rollback path.
module avalon_st_pkt_gen #(
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned EMPTY_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [7:0]            cmd_seed,
    input  logic                  cmd_err,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [EMPTY_W-1:0]    tx_empty,
    output logic                  tx_sop,
    output logic                  tx_eop,
    output logic                  tx_vld,
    input  logic                  tx_rdy,
    output logic                  in_error,
    output logic                  busy,
    output logic [31:0]           pkt_cnt
);

    localparam int unsigned B     = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = LEN_W + 1;

    localparam logic [CNT_W-1:0] B_CNT  = CNT_W'(B);
    localparam logic [7:0]       B_BYTE = 8'(B);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Elaboration-time sanity of the bus geometry
    if (DATA_WIDTH == 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $fatal(1, "avalon_st_pkt_gen: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (EMPTY_W < $clog2(B)) begin : g_bad_empty_width
        $fatal(1, "avalon_st_pkt_gen: EMPTY_W too narrow for DATA_WIDTH/8 bytes");
    end

    // Beat payload: the first min(cnt, B) byte lanes carry seed+j, MSB lane first;
    // lanes past the end of the packet stay zero.
    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [7:0]       seed,
                                                        input logic [CNT_W-1:0] cnt);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        for (int unsigned j = 0; j < B; j++) begin
            if (CNT_W'(j) < cnt) begin
                d[(B - 1 - j) * 8 +: 8] = seed + 8'(j);
            end
        end
        return d;
    endfunction

    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic [CNT_W-1:0]      rem_q;
    logic [CNT_W-1:0]      rem_d;
    logic [7:0]            seed_q;
    logic [7:0]            seed_d;
    logic                  err_q;
    logic                  err_d;

    logic                  cmd_rdy_d;
    logic                  busy_d;
    logic                  vld_d;
    logic                  sop_d;
    logic                  eop_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic [EMPTY_W-1:0]    empty_d;
    logic [31:0]           pkt_cnt_d;

    logic [CNT_W-1:0]      len_eff_c;
    logic [7:0]            beat_seed_c;
    logic [CNT_W-1:0]      beat_cnt_c;
    logic                  beat_last_c;
    logic [DATA_WIDTH-1:0] beat_data_c;
    logic [EMPTY_W-1:0]    beat_empty_c;
    logic [CNT_W-1:0]      rem_next_c;
    logic [7:0]            seed_next_c;

    // Next beat to load: from the descriptor when idle, from the running
    // byte counter / seed while sending
    always_comb begin
        len_eff_c    = (cmd_len == '0) ? CNT_W'(1) : CNT_W'(cmd_len);
        beat_seed_c  = (state_q == ST_IDLE) ? cmd_seed : seed_q;
        beat_cnt_c   = (state_q == ST_IDLE) ? len_eff_c : rem_q;
        beat_last_c  = (beat_cnt_c <= B_CNT);
        beat_data_c  = beat_data(beat_seed_c, beat_cnt_c);
        beat_empty_c = beat_last_c ? EMPTY_W'(B_CNT - beat_cnt_c) : '0;
        rem_next_c   = beat_last_c ? '0 : (beat_cnt_c - B_CNT);
        seed_next_c  = beat_seed_c + B_BYTE;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        seed_d    = seed_q;
        err_d     = err_q;
        cmd_rdy_d = cmd_rdy;
        busy_d    = busy;
        vld_d     = tx_vld;
        sop_d     = tx_sop;
        eop_d     = tx_eop;
        data_d    = tx_data;
        empty_d   = tx_empty;
        pkt_cnt_d = pkt_cnt;

        case (state_q)
            ST_IDLE: begin
                if (cmd_vld && cmd_rdy) begin
                    state_d   = ST_SEND;
                    cmd_rdy_d = 1'b0;
                    busy_d    = 1'b1;
                    vld_d     = 1'b1;
                    sop_d     = 1'b1;
                    eop_d     = beat_last_c;
                    data_d    = beat_data_c;
                    empty_d   = beat_empty_c;
                    rem_d     = rem_next_c;
                    seed_d    = seed_next_c;
                    err_d     = cmd_err;
                end
            end
            ST_SEND: begin
                if (tx_vld && tx_rdy) begin
                    if (tx_eop) begin
                        state_d   = ST_IDLE;
                        cmd_rdy_d = 1'b1;
                        busy_d    = 1'b0;
                        vld_d     = 1'b0;
                        sop_d     = 1'b0;
                        eop_d     = 1'b0;
                        data_d    = '0;
                        empty_d   = '0;
                        err_d     = 1'b0;
                        pkt_cnt_d = pkt_cnt + 32'd1;
                    end else begin
                        sop_d   = 1'b0;
                        eop_d   = beat_last_c;
                        data_d  = beat_data_c;
                        empty_d = beat_empty_c;
                        rem_d   = rem_next_c;
                        seed_d  = seed_next_c;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any packet in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            seed_q   <= '0;
            err_q    <= 1'b0;
            cmd_rdy  <= 1'b1;
            busy     <= 1'b0;
            tx_vld   <= 1'b0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
            tx_data  <= '0;
            tx_empty <= '0;
            pkt_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            seed_q   <= seed_d;
            err_q    <= err_d;
            cmd_rdy  <= cmd_rdy_d;
            busy     <= busy_d;
            tx_vld   <= vld_d;
            tx_sop   <= sop_d;
            tx_eop   <= eop_d;
            tx_data  <= data_d;
            tx_empty <= empty_d;
            pkt_cnt  <= pkt_cnt_d;
        end
    end

    // Rollback request, valid only while the eop beat of a flagged packet is offered
    assign in_error = tx_vld & tx_eop & err_q;

endmodule
